pll_reset_ctrl: RTL

Reset and lock sequencer for the core's dual-PLL clock generator. Runs on the free-running 50 MHz reference clock. Drives the PLL reset, waits for both PLLs to lock with a timeout and bounded retries, and requires a stable-lock interval before it releases the core reset. Sits between the board reset and the PLL wrapper. Its `rst_out_n` gates all logic clocked by c0/c1/c2; each consuming domain re-synchronizes it locally.

---
 rtl/pll_ctrl_pkg.sv | 23 ++
 rtl/cdc_sync2.sv | 23 ++
 rtl/pll_reset_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the dual-PLL reset/lock sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_state_t;

  // Width of a down-counter able to hold the largest of the three intervals.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low clear.
module cdc_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock sequencer: pulses the PLL reset, waits for dual lock with
// timeout and bounded retries, and releases the core reset after a stable window.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       inclk0,
  input  logic       areset_n,
  input  logic [1:0] locked_in,
  input  logic       restart,
  output logic       pll_areset,
  output logic       rst_out_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_LOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  pll_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    retry_nx, retry_inc;
  logic [1:0]    locked_sync;
  logic          lk;
  logic          entering;

  cdc_sync2 #(.WIDTH(2)) u_lock_sync (
    .clk   (inclk0),
    .rst_n (areset_n),
    .d     (locked_in),
    .q     (locked_sync)
  );

  assign lk        = &locked_sync;
  assign retry_inc = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    if (restart) begin
      state_nx = RESET;
      retry_nx = '0;
    end else begin
      unique case (state)
        RESET:     if (cnt == '0) state_nx = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lk) begin
            state_nx = STABLE;
          end else if (cnt == '0) begin
            retry_nx = retry_inc;
            state_nx = (retry_inc == RETRY_MAX) ? FAULT : RESET;
          end
        end
        STABLE: begin
          if (!lk)             state_nx = WAIT_LOCK;
          else if (cnt == '0)  state_nx = RUN;
        end
        RUN: begin
          if (!lk) begin
            state_nx = RESET;
            retry_nx = '0;
          end
        end
        FAULT:   state_nx = FAULT;
        default: state_nx = RESET;
      endcase
    end
  end

  // Restart re-enters RESET even from RESET, so it counts as an entry too.
  assign entering = restart || (state_nx != state);

  always_comb begin
    cnt_nx = cnt;
    if (entering) begin
      unique case (state_nx)
        RESET:     cnt_nx = RST_LOAD;
        WAIT_LOCK: cnt_nx = TOUT_LOAD;
        STABLE:    cnt_nx = STABLE_LOAD;
        default:   cnt_nx = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_nx = cnt - CW'(1);
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      state      <= RESET;
      cnt        <= RST_LOAD;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      rst_out_n  <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      retry_cnt  <= retry_nx;
      pll_areset <= (state_nx == RESET) || (state_nx == FAULT);
      rst_out_n  <= (state_nx == RUN);
      ready      <= (state_nx == RUN);
      fault      <= (state_nx == FAULT);
    end
  end

endmodule
